// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection and operand-forward control for the
// in-order pipeline. Tracks in-flight register writers across DEPTH
// post-decode stages (0 = E .. DEPTH-1 = W). Handles load-use stalls,
// multi-cycle execute holds and redirect flushes.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   rs_d, rt_d            decode source registers
//   rs_used_d, rt_used_d  source actually read by the decoded instruction
//   dest_d, dest_valid_d  decode destination and its write enable
//   is_load_d             result becomes forwardable at LOAD_AVAIL
//   is_multi_d            multi-cycle execute op
//   flush_in              redirect taken; kills the decode-side instruction
//   stall_f, stall_d      hold PC / hold F-D register
//   bubble_e              insert NOP into the D-E register
//   hold_e                E keeps its instruction (multi-cycle op)
//   fwd_a_e, fwd_b_e      E operand source: 0 = regfile, k = stage k result
//   busy_multi            multi-cycle op occupying E
module pipe_hazard_ctrl #(
    parameter int unsigned AW         = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_AVAIL = 2,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned FW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    input  logic          rs_used_d,
    input  logic          rt_used_d,
    input  logic [AW-1:0] dest_d,
    input  logic          dest_valid_d,
    input  logic          is_load_d,
    input  logic          is_multi_d,
    input  logic          flush_in,
    output logic          stall_f,
    output logic          stall_d,
    output logic          bubble_e,
    output logic          hold_e,
    output logic [FW-1:0] fwd_a_e,
    output logic [FW-1:0] fwd_b_e,
    output logic          busy_multi
);

    localparam int unsigned   LAST     = DEPTH - 1;
    localparam int unsigned   CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((MUL_LAT > 1) ? MUL_LAT - 1 : 0);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dest;
        logic          is_load;
    } sb_entry_t;

    typedef struct packed {
        logic          stall;
        logic [FW-1:0] fwd;
    } look_t;

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FW-1:0]         fwd_a_q, fwd_a_d;
    logic [FW-1:0]         fwd_b_q, fwd_b_d;
    look_t                 look_a, look_b;
    logic                  hold;
    logic                  load_use;

    // Youngest matching writer decides both the stall and the forward select.
    // A match in the last stage is retiring, so the regfile already has it.
    function automatic look_t lookup(input logic                  used,
                                     input logic [AW-1:0]         src,
                                     input sb_entry_t [DEPTH-1:0] sb);
        look_t r;
        r = '0;
        for (int i = int'(LAST); i >= 0; i--) begin
            if (used && (src != '0) && sb[i].valid && (sb[i].dest == src)) begin
                r.stall = sb[i].is_load && ((unsigned'(i) + 1) < LOAD_AVAIL);
                r.fwd   = (unsigned'(i) == LAST) ? '0 : FW'(unsigned'(i) + 1);
            end
        end
        return r;
    endfunction

    // A held E instruction's producer moves one stage per cycle.
    function automatic logic [FW-1:0] fwd_adv(input logic [FW-1:0] f);
        if ((f == '0) || (32'(f) == LAST)) begin
            return '0;
        end
        return f + FW'(1);
    endfunction

    assign hold       = (cnt_q != '0);
    assign hold_e     = hold;
    assign busy_multi = hold;
    assign fwd_a_e    = fwd_a_q;
    assign fwd_b_e    = fwd_b_q;

    // Stall / bubble decode: flush beats hold, hold beats load-use.
    always_comb begin
        look_a   = lookup(rs_used_d, rs_d, sb_q);
        look_b   = lookup(rt_used_d, rt_d, sb_q);
        load_use = look_a.stall | look_b.stall;
        stall_f  = !reset && !flush_in && (hold || load_use);
        stall_d  = !reset && !flush_in && (hold || load_use);
        bubble_e = !reset && (flush_in || (!hold && load_use));
    end

    // Scoreboard advance, multi-cycle counter and forward-select update.
    always_comb begin
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        for (int i = 1; i < int'(DEPTH); i++) begin
            sb_d[i] = sb_q[i-1];
        end
        if (flush_in) begin
            sb_d[0] = '0;
            cnt_d   = '0;
            fwd_a_d = '0;
            fwd_b_d = '0;
        end else if (hold) begin
            // E keeps its op; a bubble trails it into stage 1.
            sb_d[0] = sb_q[0];
            sb_d[1] = '0;
            cnt_d   = cnt_q - CW'(1);
            fwd_a_d = fwd_adv(fwd_a_q);
            fwd_b_d = fwd_adv(fwd_b_q);
        end else begin
            sb_d[0].valid   = dest_valid_d && !load_use;
            sb_d[0].dest    = dest_d;
            sb_d[0].is_load = is_load_d;
            cnt_d   = (is_multi_d && !load_use) ? CNT_LOAD : '0;
            fwd_a_d = load_use ? '0 : look_a.fwd;
            fwd_b_d = load_use ? '0 : look_b.fwd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q    <= '0;
            cnt_q   <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Three instances share the decode
// stimulus: A (DEPTH=3, LOAD_AVAIL=2, MUL_LAT=4), B (MUL_LAT=1) and
// C (DEPTH=5, LOAD_AVAIL=3). Each scenario checks one instance.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic       ru;
        logic [4:0] rt;
        logic       tu;
        logic [4:0] dest;
        logic       dv;
        logic       ld;
        logic       mul;
        logic       fl;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [4:0] rs_d, rt_d, dest_d;
    logic       rs_used_d, rt_used_d, dest_valid_d, is_load_d, is_multi_d, flush_in;

    logic       stall_f_a, stall_d_a, bubble_e_a, hold_e_a, busy_multi_a;
    logic [1:0] fwd_a_e_a, fwd_b_e_a;
    logic       stall_f_b, stall_d_b, bubble_e_b, hold_e_b, busy_multi_b;
    logic [1:0] fwd_a_e_b, fwd_b_e_b;
    logic       stall_f_c, stall_d_c, bubble_e_c, hold_e_c, busy_multi_c;
    logic [2:0] fwd_a_e_c, fwd_b_e_c;

    logic [8:0]  obs_a, obs_b;
    logic [10:0] obs_c;
    assign obs_a = {stall_f_a, stall_d_a, bubble_e_a, hold_e_a, busy_multi_a, fwd_a_e_a, fwd_b_e_a};
    assign obs_b = {stall_f_b, stall_d_b, bubble_e_b, hold_e_b, busy_multi_b, fwd_a_e_b, fwd_b_e_b};
    assign obs_c = {stall_f_c, stall_d_c, bubble_e_c, hold_e_c, busy_multi_c, fwd_a_e_c, fwd_b_e_c};

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.AW(5), .DEPTH(3), .LOAD_AVAIL(2), .MUL_LAT(4)) u_a (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
        .rs_used_d(rs_used_d), .rt_used_d(rt_used_d), .dest_d(dest_d),
        .dest_valid_d(dest_valid_d), .is_load_d(is_load_d), .is_multi_d(is_multi_d),
        .flush_in(flush_in), .stall_f(stall_f_a), .stall_d(stall_d_a),
        .bubble_e(bubble_e_a), .hold_e(hold_e_a), .fwd_a_e(fwd_a_e_a),
        .fwd_b_e(fwd_b_e_a), .busy_multi(busy_multi_a));

    pipe_hazard_ctrl #(.AW(5), .DEPTH(3), .LOAD_AVAIL(2), .MUL_LAT(1)) u_b (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
        .rs_used_d(rs_used_d), .rt_used_d(rt_used_d), .dest_d(dest_d),
        .dest_valid_d(dest_valid_d), .is_load_d(is_load_d), .is_multi_d(is_multi_d),
        .flush_in(flush_in), .stall_f(stall_f_b), .stall_d(stall_d_b),
        .bubble_e(bubble_e_b), .hold_e(hold_e_b), .fwd_a_e(fwd_a_e_b),
        .fwd_b_e(fwd_b_e_b), .busy_multi(busy_multi_b));

    pipe_hazard_ctrl #(.AW(5), .DEPTH(5), .LOAD_AVAIL(3), .MUL_LAT(4)) u_c (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
        .rs_used_d(rs_used_d), .rt_used_d(rt_used_d), .dest_d(dest_d),
        .dest_valid_d(dest_valid_d), .is_load_d(is_load_d), .is_multi_d(is_multi_d),
        .flush_in(flush_in), .stall_f(stall_f_c), .stall_d(stall_d_c),
        .bubble_e(bubble_e_c), .hold_e(hold_e_c), .fwd_a_e(fwd_a_e_c),
        .fwd_b_e(fwd_b_e_c), .busy_multi(busy_multi_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int rs, input bit ru, input int rt, input bit tu,
                                input int dest, input bit dv, input bit ld,
                                input bit mul, input bit fl);
        vec_t v;
        v.rs = 5'(rs); v.ru = ru; v.rt = 5'(rt); v.tu = tu;
        v.dest = 5'(dest); v.dv = dv; v.ld = ld; v.mul = mul; v.fl = fl;
        return v;
    endfunction

    function automatic vec_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply(input vec_t v);
        rs_d = v.rs; rs_used_d = v.ru; rt_d = v.rt; rt_used_d = v.tu;
        dest_d = v.dest; dest_valid_d = v.dv; is_load_d = v.ld;
        is_multi_d = v.mul; flush_in = v.fl;
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        reset = 1'b1;
        apply(nop());
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(mk(5, 1, 5, 1, 5, 1, 1, 1, 1));
        #3;
        total++; if (obs_a !== 9'b0)  begin bad++; $display("FAIL reset_a got=%b exp=%b", obs_a, 9'b0); end
        total++; if (obs_b !== 9'b0)  begin bad++; $display("FAIL reset_b got=%b exp=%b", obs_b, 9'b0); end
        total++; if (obs_c !== 11'b0) begin bad++; $display("FAIL reset_c got=%b exp=%b", obs_c, 11'b0); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        apply(nop());
        @(negedge clk);
        total++; if (obs_a !== 9'b0)  begin bad++; $display("FAIL post_reset_a got=%b exp=%b", obs_a, 9'b0); end
        total++; if (obs_c !== 11'b0) begin bad++; $display("FAIL post_reset_c got=%b exp=%b", obs_c, 11'b0); end
        @(posedge clk); #1;
    endtask

    task automatic test_alu_fwd();
        vec_t v[$];
        logic [8:0] e[$];
        do_reset();
        v.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(3, 1, 1, 1, 6, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_01_00);
        v.push_back(mk(0, 0, 0, 0, 8, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_00);
        v.push_back(mk(8, 1, 8, 1, 9, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(9, 0, 9, 1, 0, 0, 0, 0, 0));   e.push_back(9'b00000_10_10);
        v.push_back(nop());                           e.push_back(9'b00000_00_01);
        v.push_back(mk(0, 0, 0, 0, 11, 1, 0, 0, 0));  e.push_back(9'b00000_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_00);
        v.push_back(mk(11, 1, 0, 0, 12, 1, 0, 0, 0)); e.push_back(9'b00000_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_00);
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            total++;
            if (obs_a !== e[i]) begin bad++; $display("FAIL alu_fwd[%0d] got=%b exp=%b", i, obs_a, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        vec_t v[$];
        logic [8:0] e[$];
        do_reset();
        v.push_back(mk(0, 0, 0, 0, 5, 1, 1, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(5, 1, 0, 0, 6, 1, 0, 0, 0));   e.push_back(9'b11100_00_00);
        v.push_back(mk(5, 1, 0, 0, 6, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_10_00);
        v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(0, 1, 0, 1, 7, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_00);
        v.push_back(mk(0, 0, 0, 0, 12, 1, 1, 0, 0));  e.push_back(9'b00000_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_00);
        v.push_back(mk(0, 0, 12, 1, 13, 1, 0, 0, 0)); e.push_back(9'b00000_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_10);
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            total++;
            if (obs_a !== e[i]) begin bad++; $display("FAIL load_use[%0d] got=%b exp=%b", i, obs_a, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_multi();
        vec_t v[$];
        logic [8:0] e[$];
        do_reset();
        v.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(2, 1, 1, 0, 7, 1, 0, 1, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(7, 1, 0, 0, 8, 1, 0, 0, 0));   e.push_back(9'b11011_01_00);
        v.push_back(mk(7, 1, 0, 0, 8, 1, 0, 0, 0));   e.push_back(9'b11011_10_00);
        v.push_back(mk(7, 1, 0, 0, 8, 1, 0, 0, 0));   e.push_back(9'b11011_00_00);
        v.push_back(mk(7, 1, 0, 0, 8, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(2, 1, 0, 0, 0, 0, 0, 0, 0));   e.push_back(9'b00000_01_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_00);
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            total++;
            if (obs_a !== e[i]) begin bad++; $display("FAIL multi[%0d] got=%b exp=%b", i, obs_a, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_multi_lat1();
        vec_t v[$];
        logic [8:0] e[$];
        do_reset();
        v.push_back(mk(0, 0, 0, 0, 7, 1, 0, 1, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(7, 1, 0, 0, 8, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_01_00);
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            total++;
            if (obs_b !== e[i]) begin bad++; $display("FAIL multi_lat1[%0d] got=%b exp=%b", i, obs_b, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        vec_t v[$];
        logic [8:0] e[$];
        do_reset();
        v.push_back(mk(0, 0, 0, 0, 5, 1, 1, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(5, 1, 0, 0, 6, 1, 0, 0, 1));   e.push_back(9'b00100_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_00);
        v.push_back(mk(0, 0, 0, 0, 7, 1, 0, 1, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(7, 1, 0, 0, 8, 1, 0, 0, 0));   e.push_back(9'b11011_00_00);
        v.push_back(mk(7, 1, 0, 0, 8, 1, 0, 0, 1));   e.push_back(9'b00111_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_00);
        v.push_back(mk(1, 1, 2, 1, 9, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_00);
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            total++;
            if (obs_a !== e[i]) begin bad++; $display("FAIL flush[%0d] got=%b exp=%b", i, obs_a, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        vec_t v[$];
        logic [8:0] e[$];
        do_reset();
        apply(mk(0, 0, 0, 0, 7, 1, 0, 1, 0));
        @(posedge clk); #1;
        apply(mk(7, 1, 0, 0, 8, 1, 0, 0, 0));
        @(posedge clk); #1;
        #2;
        total++;
        if (obs_a !== 9'b11011_00_00) begin bad++; $display("FAIL mid_hold got=%b exp=%b", obs_a, 9'b11011_00_00); end
        reset = 1'b1;
        #1;
        total++;
        if (obs_a !== 9'b0) begin bad++; $display("FAIL async_reset got=%b exp=%b", obs_a, 9'b0); end
        @(posedge clk); #1;
        reset = 1'b0;
        v.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(3, 1, 1, 1, 6, 1, 0, 0, 0));   e.push_back(9'b00000_00_00);
        v.push_back(mk(1, 1, 2, 1, 9, 1, 0, 0, 0));   e.push_back(9'b00000_01_00);
        v.push_back(nop());                           e.push_back(9'b00000_00_00);
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            total++;
            if (obs_a !== e[i]) begin bad++; $display("FAIL after_reset[%0d] got=%b exp=%b", i, obs_a, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_depth5();
        vec_t v[$];
        logic [10:0] e[$];
        do_reset();
        v.push_back(mk(0, 0, 0, 0, 5, 1, 1, 0, 0));   e.push_back(11'b00000_000_000);
        v.push_back(mk(5, 1, 0, 0, 6, 1, 0, 0, 0));   e.push_back(11'b11100_000_000);
        v.push_back(mk(5, 1, 0, 0, 6, 1, 0, 0, 0));   e.push_back(11'b11100_000_000);
        v.push_back(mk(5, 1, 0, 0, 6, 1, 0, 0, 0));   e.push_back(11'b00000_000_000);
        v.push_back(nop());                           e.push_back(11'b00000_011_000);
        v.push_back(mk(0, 0, 0, 0, 4, 1, 0, 0, 0));   e.push_back(11'b00000_000_000);
        v.push_back(mk(0, 0, 0, 0, 4, 1, 0, 0, 0));   e.push_back(11'b00000_000_000);
        v.push_back(mk(4, 1, 4, 1, 9, 1, 0, 0, 0));   e.push_back(11'b00000_000_000);
        v.push_back(nop());                           e.push_back(11'b00000_001_001);
        v.push_back(mk(0, 0, 0, 0, 13, 1, 0, 0, 0));  e.push_back(11'b00000_000_000);
        v.push_back(nop());                           e.push_back(11'b00000_000_000);
        v.push_back(nop());                           e.push_back(11'b00000_000_000);
        v.push_back(nop());                           e.push_back(11'b00000_000_000);
        v.push_back(mk(0, 0, 13, 1, 14, 1, 0, 0, 0)); e.push_back(11'b00000_000_000);
        v.push_back(nop());                           e.push_back(11'b00000_000_100);
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            @(negedge clk);
            total++;
            if (obs_c !== e[i]) begin bad++; $display("FAIL depth5[%0d] got=%b exp=%b", i, obs_c, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        apply(nop());
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_multi();
        test_multi_lat1();
        test_flush();
        test_async_reset();
        test_depth5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
